// File: rtl/ft_tx_gen.sv
// FT60x-style transmit pattern generator: streams counter/LFSR/walking-one/constant
// words to the FT bus with TXE flow control, finite or continuous bursts.
module ft_tx_gen #(
  parameter int              DATA_W    = 16,
  parameter logic [DATA_W-1:0] CONST_PAT = '1,
  localparam int             BE_W      = DATA_W / 8
) (
  input  logic              ft_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [15:0]       burst_len,
  input  logic              ft_txe_n,
  input  logic              ft_rxf_n,
  output logic [DATA_W-1:0] ft_data,
  output logic [BE_W-1:0]   ft_be,
  output logic              ft_wr_n,
  output logic              ft_rd_n,
  output logic              ft_oe_n,
  output logic              busy,
  output logic              done,
  output logic [31:0]       word_count,
  output logic [7:0]        led
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

  // Fibonacci taps as a bit mask: 16,14,13,11 or 32,22,2,1 (1-based)
  localparam logic [31:0]       TAP_ALL  = (DATA_W == 32) ? 32'h8020_0003 : 32'h0000_B400;
  localparam logic [DATA_W-1:0] TAP_MASK = TAP_ALL[DATA_W-1:0];

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wr_n_q, wr_n_d;
  logic [15:0]         rem_q, rem_d;
  logic [1:0]          mode_q, mode_d;
  logic                cont_q, cont_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [31:0]         wc_q, wc_d;
  logic                done_seen_q, done_seen_d;
  logic                stall_seen_q, stall_seen_d;
  logic                acc_prev_q, acc_prev_d;
  logic                accept;
  logic                unused_rxf;

  assign unused_rxf = ft_rxf_n;

  function automatic logic [DATA_W-1:0] seed_of(input logic [1:0] m);
    case (m)
      2'd0:    seed_of = '0;
      2'd3:    seed_of = CONST_PAT;
      default: seed_of = DATA_W'(1);
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] next_of(input logic [1:0] m, input logic [DATA_W-1:0] d);
    case (m)
      2'd0:    next_of = d + DATA_W'(1);
      2'd1:    next_of = {d[DATA_W-2:0], ^(d & TAP_MASK)};
      2'd2:    next_of = {d[DATA_W-2:0], d[DATA_W-1]};
      default: next_of = CONST_PAT;
    endcase
  endfunction

  assign accept = ~wr_n_q & ~ft_txe_n;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    rem_d        = rem_q;
    mode_d       = mode_q;
    cont_d       = cont_q;
    wc_d         = wc_q;
    done_seen_d  = done_seen_q;
    stall_seen_d = stall_seen_q;
    acc_prev_d   = accept;

    if (accept && wc_q != 32'hFFFF_FFFF) wc_d = wc_q + 32'd1;
    if (~wr_n_q && ft_txe_n) stall_seen_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_BURST;
          mode_d       = mode;
          cont_d       = (burst_len == 16'd0);
          rem_d        = burst_len;
          data_d       = seed_of(mode);
          done_seen_d  = 1'b0;
          stall_seen_d = 1'b0;
        end
      end
      S_BURST: begin
        if (accept) begin
          data_d = next_of(mode_q, data_q);
          if (!cont_q) rem_d = rem_q - 16'd1;
        end
        // stop wins over completion: no done pulse on an aborted burst
        if (stop)                                   state_d = S_IDLE;
        else if (accept && !cont_q && rem_q == 16'd1) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    wr_n_d = ~((state_d == S_BURST) && ~ft_txe_n);
    busy_d = (state_d == S_BURST);
    done_d = (state_d == S_DONE);
    if (done_d) done_seen_d = 1'b1;
  end

  always_ff @(posedge ft_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      data_q       <= '0;
      wr_n_q       <= 1'b1;
      rem_q        <= '0;
      mode_q       <= '0;
      cont_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wc_q         <= '0;
      done_seen_q  <= 1'b0;
      stall_seen_q <= 1'b0;
      acc_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      wr_n_q       <= wr_n_d;
      rem_q        <= rem_d;
      mode_q       <= mode_d;
      cont_q       <= cont_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wc_q         <= wc_d;
      done_seen_q  <= done_seen_d;
      stall_seen_q <= stall_seen_d;
      acc_prev_q   <= acc_prev_d;
    end
  end

  assign ft_data    = data_q;
  assign ft_be      = '1;
  assign ft_wr_n    = wr_n_q;
  assign ft_rd_n    = 1'b1;
  assign ft_oe_n    = 1'b1;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_count = wc_q;
  assign led        = {{4{acc_prev_q}}, 1'b0, stall_seen_q, done_seen_q, busy_q};

endmodule

// File: tb/tb_ft_tx_gen.sv
// Directed bench for ft_tx_gen: 16-bit instance for most cases, 32-bit instance
// for the walking-one wrap.
`timescale 1ns/1ps
module tb_ft_tx_gen;

  logic        clk = 1'b0;
  logic        rst, start, stop, ft_txe_n, ft_rxf_n;
  logic [1:0]  mode;
  logic [15:0] burst_len;

  logic [15:0] d16;  logic [1:0] be16;
  logic        wr_n16, rd_n16, oe_n16, busy16, done16;
  logic [31:0] wc16; logic [7:0] led16;

  logic [31:0] d32;  logic [3:0] be32;
  logic        wr_n32, rd_n32, oe_n32, busy32, done32;
  logic [31:0] wc32; logic [7:0] led32;

  int n_cmp = 0;
  int n_bad = 0;
  int ndone;
  logic [15:0] acc_q[$];

  localparam logic [15:0] LFSR_EXP [17] = '{
    16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080,
    16'h0100, 16'h0200, 16'h0400, 16'h0801, 16'h1002, 16'h2005, 16'h400B, 16'h8016,
    16'h002D};

  always #5 clk = ~clk;

  ft_tx_gen #(.DATA_W(16)) u16 (
    .ft_clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .burst_len(burst_len), .ft_txe_n(ft_txe_n), .ft_rxf_n(ft_rxf_n),
    .ft_data(d16), .ft_be(be16), .ft_wr_n(wr_n16), .ft_rd_n(rd_n16),
    .ft_oe_n(oe_n16), .busy(busy16), .done(done16), .word_count(wc16), .led(led16));

  ft_tx_gen #(.DATA_W(32)) u32 (
    .ft_clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .burst_len(burst_len), .ft_txe_n(ft_txe_n), .ft_rxf_n(ft_rxf_n),
    .ft_data(d32), .ft_be(be32), .ft_wr_n(wr_n32), .ft_rd_n(rd_n32),
    .ft_oe_n(oe_n32), .busy(busy32), .done(done32), .word_count(wc32), .led(led32));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [15:0] l);
    mode = m; burst_len = l; ft_txe_n = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drives txe/stop per cycle, logs accepted words; ends on done or on the stop edge.
  task automatic run(input int stall_at, input int stall_len, input int stop_at, input int budget);
    int   n = 0;
    int   st = 0;
    logic txe, acc, stp;
    logic ended = 1'b0;
    acc_q.delete();
    ndone = 0;
    for (int c = 0; c < budget && !ended; c++) begin
      txe = (n == stall_at) && (st < stall_len);
      if (txe) st++;
      ft_txe_n = txe;
      acc = !wr_n16 && !txe;
      stp = acc && (n + 1 == stop_at);
      stop = stp;
      if (acc) begin acc_q.push_back(d16); n++; end
      tick();
      stop = 1'b0;
      if (done16) ndone++;
      if (stp || done16) ended = 1'b1;
    end
    ft_txe_n = 1'b0;
    chk("run_end", ended, 1'b1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0; burst_len = 16'd0;
    ft_txe_n = 1'b1; ft_rxf_n = 1'b1;

    // reset state
    do_reset();
    chk("rst_data", d16, 16'h0);
    chk("rst_wr_n", wr_n16, 1'b1);
    chk("rst_busy", busy16, 1'b0);
    chk("rst_done", done16, 1'b0);
    chk("rst_wc", wc16, 32'd0);
    chk("rst_led", led16, 8'h00);
    chk("const_pins", {be16, rd_n16, oe_n16, be32}, {2'b11, 1'b1, 1'b1, 4'hF});

    // counter, 4 words, no stalls
    do_start(2'd0, 16'd4);
    chk("t1_busy", busy16, 1'b1);
    chk("t1_led_busy", led16, 8'h01);
    run(-1, 0, -1, 20);
    chk("t1_n", acc_q.size(), 4);
    for (int i = 0; i < acc_q.size(); i++) chk($sformatf("t1_w%0d", i), acc_q[i], i);
    chk("t1_done", done16, 1'b1);
    chk("t1_wr_n_done", wr_n16, 1'b1);
    chk("t1_wc", wc16, 32'd4);
    chk("t1_led_done", led16, 8'hF2);
    tick();
    chk("t1_done_once", done16, 1'b0);
    chk("t1_led_idle", led16, 8'h02);
    chk("t1_ndone", ndone, 1);

    // counter, 8 words, 3-cycle txe stall while word 2 is presented
    do_reset();
    do_start(2'd0, 16'd8);
    run(2, 3, -1, 40);
    chk("t2_n", acc_q.size(), 8);
    for (int i = 0; i < acc_q.size(); i++) chk($sformatf("t2_w%0d", i), acc_q[i], i);
    chk("t2_led", led16, 8'hF6);
    chk("t2_wc", wc16, 32'd8);

    // LFSR, 17 words, crosses every tap
    do_reset();
    do_start(2'd1, 16'd17);
    run(-1, 0, -1, 40);
    chk("t3_n", acc_q.size(), 17);
    for (int i = 0; i < acc_q.size() && i < 17; i++) chk($sformatf("t3_w%0d", i), acc_q[i], LFSR_EXP[i]);

    // walking one on the 32-bit instance, wraps back to 1
    do_reset();
    do_start(2'd2, 16'd33);
    for (int i = 0; i < 33; i++) begin
      chk($sformatf("t4_wr_n%0d", i), wr_n32, 1'b0);
      chk($sformatf("t4_w%0d", i), d32, (i < 32) ? (32'h1 << i) : 32'h1);
      tick();
    end
    chk("t4_done", done32, 1'b1);
    chk("t4_wc", wc32, 32'd33);

    // constant pattern
    do_reset();
    do_start(2'd3, 16'd2);
    run(-1, 0, -1, 10);
    chk("t5_n", acc_q.size(), 2);
    for (int i = 0; i < acc_q.size(); i++) chk($sformatf("t5_w%0d", i), acc_q[i], 16'hFFFF);

    // continuous burst aborted after 10 accepts
    do_reset();
    do_start(2'd0, 16'd0);
    run(-1, 0, 10, 40);
    chk("t6_wr_n", wr_n16, 1'b1);
    chk("t6_busy", busy16, 1'b0);
    chk("t6_ndone", ndone, 0);
    chk("t6_wc", wc16, 32'd10);
    chk("t6_n", acc_q.size(), 10);
    for (int i = 0; i < acc_q.size(); i++) chk($sformatf("t6_w%0d", i), acc_q[i], i);
    tick();
    chk("t6_done_after", done16, 1'b0);
    chk("t6_wc_after", wc16, 32'd10);

    // stop coincident with the last accept of a 5-word burst
    do_reset();
    do_start(2'd0, 16'd5);
    run(-1, 0, 5, 20);
    chk("t7_wc", wc16, 32'd5);
    chk("t7_ndone", ndone, 0);
    chk("t7_busy", busy16, 1'b0);
    tick();
    chk("t7_done_after", done16, 1'b0);

    // start ignored mid-burst, then reset mid-burst and restart
    do_reset();
    do_start(2'd1, 16'd0);
    tick();
    mode = 2'd0; start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("t8_mid", d16, 16'h0008);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t8_rst_data", d16, 16'h0);
    chk("t8_rst_wr_n", wr_n16, 1'b1);
    chk("t8_rst_busy", busy16, 1'b0);
    chk("t8_rst_done", done16, 1'b0);
    chk("t8_rst_wc", wc16, 32'd0);
    chk("t8_rst_led", led16, 8'h00);
    tick();
    chk("t8_no_more", wc16, 32'd0);
    do_start(2'd1, 16'd3);
    chk("t8_seed", d16, 16'h0001);
    chk("t8_wr_n", wr_n16, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
